ram_prog_arbiter: RTL and testbench

- Shares the 16x8 program/data RAM between the CPU microcode control lines (mi/ri/ro) and an external byte-wide programming port.
- Owns the memory address register (MAR) and all RAM strobes.
- Requests CPU ownership on prog_mode, stalls the CPU at an instruction boundary, then accepts programming bytes through a valid/ready handshake with an auto-incrementing address.
- Sits between the instruction decoder/bus and the RAM macro.

---
 rtl/cpu8_pkg.sv | 18 +
 rtl/ram_prog_arbiter_if.sv | 50 +++++
 rtl/ram_wr_pulse.sv | 38 +++
 rtl/ram_prog_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ram_prog_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared types and default widths for the 8-bit CPU slice.
//   CPU8_ADDR_W / CPU8_DATA_W : RAM address and data widths also used by the decoder.
//   ram_arb_state_t           : state encoding of ram_prog_arbiter.
//   When RAM_PROG_READBACK_EN is defined, the arbiter uses the VERIFY state.
package cpu8_pkg;

    localparam int CPU8_ADDR_W = 4;
    localparam int CPU8_DATA_W = 8;

    typedef enum logic [2:0] {
        CPU    = 3'd0,
        DRAIN  = 3'd1,
        PROG   = 3'd2,
        WRITE  = 3'd3,
        VERIFY = 3'd4
    } ram_arb_state_t;

endpackage

// File: rtl/ram_prog_arbiter_if.sv
// ram_prog_arbiter_if: bundles the CPU strobes, the programming port and the
// RAM macro pins that meet at the RAM arbiter.
//   slave  modport : the arbiter (samples CPU/programmer inputs, drives RAM pins)
//   master modport : the surrounding CPU, programmer and RAM macro
// Programming handshake: a beat transfers on a rising clk edge where
// prog_valid and prog_ready are both 1; prog_is_addr/prog_data must be stable
// while prog_valid is 1, and prog_ready does not depend on prog_valid.
// dbg_state exposes the arbiter FSM state for observation.
interface ram_prog_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    import cpu8_pkg::*;

    logic              prog_mode;
    logic              cpu_boundary;
    logic              cpu_hold;
    logic              cpu_mar_load;
    logic              cpu_ram_we;
    logic              cpu_ram_oe;
    logic [DATA_W-1:0] cpu_bus;
    logic              prog_valid;
    logic              prog_ready;
    logic              prog_is_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_oe;
    logic              prog_owner;
    logic              prog_wrap;
    logic              prog_err;
    ram_arb_state_t    dbg_state;

    modport slave (
        input  prog_mode, cpu_boundary, cpu_mar_load, cpu_ram_we, cpu_ram_oe,
               cpu_bus, prog_valid, prog_is_addr, prog_data, ram_rdata,
        output cpu_hold, prog_ready, ram_addr, ram_wdata, ram_we, ram_oe,
               prog_owner, prog_wrap, prog_err, dbg_state
    );

    modport master (
        output prog_mode, cpu_boundary, cpu_mar_load, cpu_ram_we, cpu_ram_oe,
               cpu_bus, prog_valid, prog_is_addr, prog_data, ram_rdata,
        input  cpu_hold, prog_ready, ram_addr, ram_wdata, ram_we, ram_oe,
               prog_owner, prog_wrap, prog_err, dbg_state
    );

endinterface

// File: rtl/ram_wr_pulse.sv
// ram_wr_pulse: write-strobe window generator for programmer writes.
//   clk, rst   : clock, asynchronous active-low reset
//   start_i    : begin a window (loads the down-counter)
//   active_o   : high for exactly WR_CYCLES clocks after start_i
//   done_o     : high in the last clock of the window
module ram_wr_pulse #(
    parameter int WR_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic active_o,
    output logic done_o
);

    localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          active_q;

    // Counter holds the number of window clocks still to come after this one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            cnt_q    <= CW'(WR_CYCLES - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) active_q <= 1'b0;
            else             cnt_q    <= cnt_q - 1'b1;
        end
    end

    assign active_o = active_q;
    assign done_o   = active_q && (cnt_q == '0);

endmodule

// File: rtl/ram_prog_arbiter.sv
// ram_prog_arbiter: shares the program/data RAM between the CPU decoder strobes
// (mi/ri/ro) and a byte-wide programming port. Owns the MAR and all RAM strobes.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ram_prog_arbiter_if.slave (CPU strobes, programming beats, RAM pins)
// Flow: prog_mode -> DRAIN (CPU held) -> cpu_boundary -> PROG (beats accepted);
// a data beat runs a WR_CYCLES-long write at the programming address, which then
// auto-increments. Define RAM_PROG_READBACK_EN to add a VERIFY read after every
// write that sets sticky prog_err on mismatch; otherwise prog_err is tied 0.
module ram_prog_arbiter
    import cpu8_pkg::*;
#(
    parameter int ADDR_W    = CPU8_ADDR_W,
    parameter int DATA_W    = CPU8_DATA_W,
    parameter int WR_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_prog_arbiter_if.slave  bus
);

    ram_arb_state_t    state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hold_q;
    logic              ready_q;
    logic              owner_q;
    logic              wrap_q;
    logic              wr_start;
    logic              wr_active;
    logic              wr_done;

    assign wr_start = (state_q == PROG) && bus.prog_valid && !bus.prog_is_addr;

    ram_wr_pulse #(.WR_CYCLES(WR_CYCLES)) u_wr_pulse (
        .clk      (clk),
        .rst      (rst),
        .start_i  (wr_start),
        .active_o (wr_active),
        .done_o   (wr_done)
    );

`ifdef RAM_PROG_READBACK_EN
    logic err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.ram_rdata;
`endif

    // hold/ready/owner are registered alongside each transition so they always
    // equal the decode of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CPU;
            mar_q   <= '0;
            paddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
            owner_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef RAM_PROG_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                CPU: begin
                    if (bus.cpu_mar_load) mar_q <= bus.cpu_bus[ADDR_W-1:0];
                    if (bus.prog_mode) begin
                        state_q <= DRAIN;
                        hold_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    // The CPU finishes its current instruction, so mi still counts.
                    if (bus.cpu_mar_load) mar_q <= bus.cpu_bus[ADDR_W-1:0];
                    if (!bus.prog_mode) begin
                        state_q <= CPU;
                        hold_q  <= 1'b0;
                    end else if (bus.cpu_boundary) begin
                        state_q <= PROG;
                        owner_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                PROG: begin
                    // A presented beat wins over a simultaneous prog_mode release.
                    if (bus.prog_valid) begin
                        if (bus.prog_is_addr) begin
                            paddr_q <= bus.prog_data[ADDR_W-1:0];
                        end else begin
                            wdata_q <= bus.prog_data;
                            state_q <= WRITE;
                            ready_q <= 1'b0;
                        end
                    end else if (!bus.prog_mode) begin
                        state_q <= CPU;
                        hold_q  <= 1'b0;
                        owner_q <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_done) begin
`ifdef RAM_PROG_READBACK_EN
                        state_q <= VERIFY;
`else
                        paddr_q <= paddr_q + 1'b1;
                        if (&paddr_q) wrap_q <= 1'b1;
                        if (bus.prog_mode) begin
                            state_q <= PROG;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= CPU;
                            hold_q  <= 1'b0;
                            owner_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef RAM_PROG_READBACK_EN
                VERIFY: begin
                    if (bus.ram_rdata != wdata_q) err_q <= 1'b1;
                    paddr_q <= paddr_q + 1'b1;
                    if (&paddr_q) wrap_q <= 1'b1;
                    if (bus.prog_mode) begin
                        state_q <= PROG;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= CPU;
                        hold_q  <= 1'b0;
                        owner_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= CPU;
                    hold_q  <= 1'b0;
                    owner_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM pin mux: CPU strobes pass straight through until the programmer owns the RAM.
    always_comb begin
        bus.ram_addr  = mar_q;
        bus.ram_wdata = bus.cpu_bus;
        bus.ram_we    = bus.cpu_ram_we;
        bus.ram_oe    = bus.cpu_ram_oe;
        case (state_q)
            PROG: begin
                bus.ram_addr  = paddr_q;
                bus.ram_wdata = wdata_q;
                bus.ram_we    = 1'b0;
                bus.ram_oe    = 1'b0;
            end
            WRITE: begin
                bus.ram_addr  = paddr_q;
                bus.ram_wdata = wdata_q;
                bus.ram_we    = wr_active;
                bus.ram_oe    = 1'b0;
            end
`ifdef RAM_PROG_READBACK_EN
            VERIFY: begin
                bus.ram_addr  = paddr_q;
                bus.ram_wdata = wdata_q;
                bus.ram_we    = 1'b0;
                bus.ram_oe    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.cpu_hold   = hold_q;
    assign bus.prog_ready = ready_q;
    assign bus.prog_owner = owner_q;
    assign bus.prog_wrap  = wrap_q;
    assign bus.dbg_state  = state_q;
`ifdef RAM_PROG_READBACK_EN
    assign bus.prog_err   = err_q;
`else
    assign bus.prog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_prog_arbiter.sv
// tb_ram_prog_arbiter: directed bench for ram_prog_arbiter (WR_CYCLES=2).
// A vector table walks CPU pass-through, drain, a programming burst, address
// wrap and release mid-write; hand-written sequences cover beat/release
// collision, exit without a beat and asynchronous reset mid-write.
// With RAM_PROG_READBACK_EN defined, a readback sequence replaces the table.
module tb_ram_prog_arbiter;
    import cpu8_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int WR = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ram_prog_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_prog_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic       pm, bd, mi, ri, ro;
        logic [7:0] cbus;
        logic       pv, pa;
        logic [7:0] pd;
        logic       hold, rdy, own;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       we, oe, wrap;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mkv(
        input logic pm, bd, mi, ri, ro, input logic [7:0] cbus,
        input logic pv, pa, input logic [7:0] pd,
        input logic hold, rdy, own, input logic [3:0] addr, input logic [7:0] wd,
        input logic we, oe, wrap);
        vec_t v;
        v.pm = pm; v.bd = bd; v.mi = mi; v.ri = ri; v.ro = ro; v.cbus = cbus;
        v.pv = pv; v.pa = pa; v.pd = pd;
        v.hold = hold; v.rdy = rdy; v.own = own; v.addr = addr; v.wd = wd;
        v.we = we; v.oe = oe; v.wrap = wrap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.prog_mode = 0; bus.cpu_boundary = 0; bus.cpu_mar_load = 0;
        bus.cpu_ram_we = 0; bus.cpu_ram_oe = 0; bus.cpu_bus = '0;
        bus.prog_valid = 0; bus.prog_is_addr = 0; bus.prog_data = '0;
        bus.ram_rdata = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.prog_mode = v.pm; bus.cpu_boundary = v.bd; bus.cpu_mar_load = v.mi;
        bus.cpu_ram_we = v.ri; bus.cpu_ram_oe = v.ro; bus.cpu_bus = v.cbus;
        bus.prog_valid = v.pv; bus.prog_is_addr = v.pa; bus.prog_data = v.pd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.hold", i),  32'(bus.cpu_hold),   32'(v.hold));
        chk($sformatf("v%0d.ready", i), 32'(bus.prog_ready), 32'(v.rdy));
        chk($sformatf("v%0d.owner", i), 32'(bus.prog_owner), 32'(v.own));
        chk($sformatf("v%0d.addr", i),  32'(bus.ram_addr),   32'(v.addr));
        chk($sformatf("v%0d.wdata", i), 32'(bus.ram_wdata),  32'(v.wd));
        chk($sformatf("v%0d.we", i),    32'(bus.ram_we),     32'(v.we));
        chk($sformatf("v%0d.oe", i),    32'(bus.ram_oe),     32'(v.oe));
        chk($sformatf("v%0d.wrap", i),  32'(bus.prog_wrap),  32'(v.wrap));
        chk($sformatf("v%0d.err", i),   32'(bus.prog_err),   32'(0));
    endtask

    // Enter PROG from CPU: one cycle to DRAIN, one with boundary to PROG.
    task automatic enter_prog();
        @(negedge clk);
        bus.prog_mode = 1; bus.cpu_boundary = 1;
        @(negedge clk);
        @(negedge clk);
        bus.cpu_boundary = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b0;

        //               pm bd mi ri ro bus   pv pa pd    | hold rdy own addr wd    we oe wrap
        vecs[0]  = mkv(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0);
        vecs[1]  = mkv(0, 0, 1, 0, 0, 8'h0B, 0, 0, 8'h00, 0, 0, 0, 4'h0, 8'h0B, 0, 0, 0);
        vecs[2]  = mkv(0, 0, 0, 0, 1, 8'h5C, 0, 0, 8'h00, 0, 0, 0, 4'hB, 8'h5C, 0, 1, 0);
        vecs[3]  = mkv(0, 0, 0, 1, 0, 8'h77, 0, 0, 8'h00, 0, 0, 0, 4'hB, 8'h77, 1, 0, 0);
        vecs[4]  = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hB, 8'h00, 0, 0, 0);
        vecs[5]  = mkv(1, 0, 0, 0, 1, 8'h12, 0, 0, 8'h00, 1, 0, 0, 4'hB, 8'h12, 0, 1, 0);
        vecs[6]  = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 4'hB, 8'h00, 0, 0, 0);
        vecs[7]  = mkv(1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 4'hB, 8'h00, 0, 0, 0);
        vecs[8]  = mkv(1, 0, 1, 1, 1, 8'h09, 1, 1, 8'h03, 1, 1, 1, 4'h0, 8'h00, 0, 0, 0);
        vecs[9]  = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hA1, 1, 1, 1, 4'h3, 8'h00, 0, 0, 0);
        vecs[10] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hB2, 1, 0, 1, 4'h3, 8'hA1, 1, 0, 0);
        vecs[11] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hB2, 1, 0, 1, 4'h3, 8'hA1, 1, 0, 0);
        vecs[12] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hB2, 1, 1, 1, 4'h4, 8'hA1, 0, 0, 0);
        vecs[13] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h4, 8'hB2, 1, 0, 0);
        vecs[14] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h4, 8'hB2, 1, 0, 0);
        vecs[15] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h0F, 1, 1, 1, 4'h5, 8'hB2, 0, 0, 0);
        vecs[16] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'h55, 1, 1, 1, 4'hF, 8'hB2, 0, 0, 0);
        vecs[17] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'hF, 8'h55, 1, 0, 0);
        vecs[18] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'hF, 8'h55, 1, 0, 0);
        vecs[19] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'h66, 1, 1, 1, 4'h0, 8'h55, 0, 0, 1);
        vecs[20] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h0, 8'h66, 1, 0, 1);
        vecs[21] = mkv(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h0, 8'h66, 1, 0, 1);
        vecs[22] = mkv(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'hC3, 1, 1, 1, 4'h1, 8'h66, 0, 0, 1);
        vecs[23] = mkv(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h1, 8'hC3, 1, 0, 1);
        vecs[24] = mkv(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 4'h1, 8'hC3, 1, 0, 1);
        vecs[25] = mkv(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4'hB, 8'h00, 0, 0, 1);

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst.hold",  32'(bus.cpu_hold),   32'(0));
        chk("rst.ready", 32'(bus.prog_ready), 32'(0));
        chk("rst.owner", 32'(bus.prog_owner), 32'(0));
        chk("rst.we",    32'(bus.ram_we),     32'(0));
        chk("rst.oe",    32'(bus.ram_oe),     32'(0));
        chk("rst.addr",  32'(bus.ram_addr),   32'(0));
        chk("rst.wrap",  32'(bus.prog_wrap),  32'(0));
        chk("rst.err",   32'(bus.prog_err),   32'(0));
        chk("rst.state", 32'(bus.dbg_state),  32'(CPU));
        @(negedge clk);
        rst = 1'b1;

`ifndef RAM_PROG_READBACK_EN
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end
        idle();

        // beat accepted in the same cycle prog_mode drops; paddr is 2 here
        enter_prog();
        #1;
        chk("A.ready", 32'(bus.prog_ready), 32'(1));
        bus.prog_mode = 0; bus.prog_valid = 1; bus.prog_is_addr = 0; bus.prog_data = 8'h9A;
        @(negedge clk);
        bus.prog_valid = 0;
        #1;
        chk("A.we1",   32'(bus.ram_we),     32'(1));
        chk("A.addr",  32'(bus.ram_addr),   32'(2));
        chk("A.wdata", 32'(bus.ram_wdata),  32'(8'h9A));
        chk("A.ready0",32'(bus.prog_ready), 32'(0));
        @(negedge clk);
        #1;
        chk("A.we2",   32'(bus.ram_we),     32'(1));
        @(negedge clk);
        #1;
        chk("A.hold",  32'(bus.cpu_hold),   32'(0));
        chk("A.owner", 32'(bus.prog_owner), 32'(0));
        chk("A.we_off",32'(bus.ram_we),     32'(0));

        // exit PROG with no beat; paddr persisted at 3
        enter_prog();
        #1;
        chk("B.ready", 32'(bus.prog_ready), 32'(1));
        chk("B.paddr", 32'(bus.ram_addr),   32'(3));
        bus.prog_mode = 0;
        @(negedge clk);
        #1;
        chk("B.hold",  32'(bus.cpu_hold),   32'(0));
        chk("B.owner", 32'(bus.prog_owner), 32'(0));
        chk("B.ready0",32'(bus.prog_ready), 32'(0));
        chk("B.state", 32'(bus.dbg_state),  32'(CPU));

        // asynchronous reset in the middle of a write
        enter_prog();
        bus.prog_valid = 1; bus.prog_is_addr = 0; bus.prog_data = 8'h44;
        @(negedge clk);
        bus.prog_valid = 0;
        #1;
        chk("C.we_on", 32'(bus.ram_we),     32'(1));
        chk("C.addr",  32'(bus.ram_addr),   32'(3));
        #1;
        rst = 1'b0;
        #1;
        chk("C.we",    32'(bus.ram_we),     32'(0));
        chk("C.hold",  32'(bus.cpu_hold),   32'(0));
        chk("C.owner", 32'(bus.prog_owner), 32'(0));
        chk("C.ready", 32'(bus.prog_ready), 32'(0));
        chk("C.wrap",  32'(bus.prog_wrap),  32'(0));
        chk("C.mar",   32'(bus.ram_addr),   32'(0));
        chk("C.state", 32'(bus.dbg_state),  32'(CPU));
        idle();
        @(negedge clk);
        rst = 1'b1;
        enter_prog();
        #1;
        chk("C.paddr", 32'(bus.ram_addr),   32'(0));
        bus.prog_mode = 0;
        @(negedge clk);
`else
        // readback: matching data leaves prog_err clear, mismatch sets it
        enter_prog();
        bus.prog_valid = 1; bus.prog_is_addr = 0; bus.prog_data = 8'h5A;
        bus.ram_rdata = 8'h5A;
        @(negedge clk);
        bus.prog_valid = 0;
        repeat (WR) @(negedge clk);
        #1;
        chk("R.v_oe",   32'(bus.ram_oe),   32'(1));
        chk("R.v_addr", 32'(bus.ram_addr), 32'(0));
        @(negedge clk);
        #1;
        chk("R.err0",   32'(bus.prog_err), 32'(0));
        chk("R.paddr",  32'(bus.ram_addr), 32'(1));
        bus.prog_valid = 1; bus.prog_data = 8'h6B; bus.ram_rdata = 8'h00;
        @(negedge clk);
        bus.prog_valid = 0;
        repeat (WR + 1) @(negedge clk);
        #1;
        chk("R.err1",   32'(bus.prog_err), 32'(1));
        bus.prog_mode = 0;
        @(negedge clk);
        #1;
        chk("R.sticky", 32'(bus.prog_err), 32'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
